// File: rtl/ysyx_22041207_div_unit_pkg.sv
// Shared types for the radix-2 restoring divider: FSM states, latched operand flags,
// and the iteration-counter width helper.
package ysyx_22041207_div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  typedef struct packed {
    logic neg_q;  // quotient must be negated at FIX
    logic neg_r;  // remainder must be negated at FIX
    logic div0;   // divisor is zero after word extension
    logic ovf;    // signed most-negative / -1
    logic word;   // 32-bit W operation
  } div_flags_t;

  function automatic int div_cnt_width(input int xlen);
    return $clog2(xlen) + 1;
  endfunction

endpackage

// File: rtl/ysyx_22041207_div_abs.sv
// Combinational operand conditioner: word extension, magnitudes, result signs and
// special-case flags. Sampled by the divider only on the accept edge.
module ysyx_22041207_div_abs
  import ysyx_22041207_div_unit_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  input  logic            i_signed,
  input  logic            i_word,
  output logic [XLEN-1:0] o_a_abs,
  output logic [XLEN-1:0] o_b_abs,
  output logic [XLEN-1:0] o_a_ext,
  output div_flags_t      o_flags
);

  logic [XLEN-1:0] w_a_ext;
  logic [XLEN-1:0] w_b_ext;
  logic [XLEN-1:0] w_min;
  logic            w_word;
  logic            w_sa;
  logic            w_sb;

  generate
    if (XLEN > 32) begin : g_word
      always_comb begin
        w_word  = i_word;
        w_a_ext = i_dividend;
        w_b_ext = i_divisor;
        w_min   = {1'b1, {(XLEN-1){1'b0}}};
        if (i_word) begin
          w_a_ext = {{(XLEN-32){i_signed & i_dividend[31]}}, i_dividend[31:0]};
          w_b_ext = {{(XLEN-32){i_signed & i_divisor[31]}}, i_divisor[31:0]};
          w_min   = {{(XLEN-31){1'b1}}, 31'b0};
        end
      end
    end else begin : g_noword
      always_comb begin
        w_word  = 1'b0;
        w_a_ext = i_dividend;
        w_b_ext = i_divisor;
        w_min   = {1'b1, {(XLEN-1){1'b0}}};
      end
    end
  endgenerate

  assign w_sa = i_signed & w_a_ext[XLEN-1];
  assign w_sb = i_signed & w_b_ext[XLEN-1];

  // abs(most-negative) wraps to itself, which is the correct unsigned magnitude
  assign o_a_abs = w_sa ? -w_a_ext : w_a_ext;
  assign o_b_abs = w_sb ? -w_b_ext : w_b_ext;
  assign o_a_ext = w_a_ext;

  assign o_flags.neg_q = w_sa ^ w_sb;
  assign o_flags.neg_r = w_sa;
  assign o_flags.div0  = (w_b_ext == '0);
  assign o_flags.ovf   = i_signed & (w_a_ext == w_min) & (&w_b_ext);
  assign o_flags.word  = w_word;

endmodule

// File: rtl/ysyx_22041207_div_unit.sv
// Multi-cycle radix-2 restoring divider returning quotient and remainder with RISC-V
// divide-by-zero / overflow results. Optional DIV_FAST_SPECIAL_EN skips the iterations
// for special cases.
module ysyx_22041207_div_unit
  import ysyx_22041207_div_unit_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            flush,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            div_signed,
  input  logic            div_word,
  output logic            ready,
  output logic            out_valid,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CNT_W = div_cnt_width(XLEN);

  div_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_div;
  logic [XLEN-1:0] r_a_ext;
  div_flags_t      r_flags;
  logic            r_ready;
  logic            r_out_valid;
  logic [XLEN-1:0] r_quotient;
  logic [XLEN-1:0] r_remainder;

  logic [XLEN-1:0] w_a_abs;
  logic [XLEN-1:0] w_b_abs;
  logic [XLEN-1:0] w_a_ext;
  div_flags_t      w_flags;

  ysyx_22041207_div_abs #(.XLEN(XLEN)) u_abs (
    .i_dividend (dividend),
    .i_divisor  (divisor),
    .i_signed   (div_signed),
    .i_word     (div_word),
    .o_a_abs    (w_a_abs),
    .o_b_abs    (w_b_abs),
    .o_a_ext    (w_a_ext),
    .o_flags    (w_flags)
  );

  // One restoring step: the shifted partial remainder needs XLEN+1 bits
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic            w_fits;
  logic [XLEN-1:0] w_rem_next;
  logic            w_last;

  assign w_shift    = {r_rem, r_quo[XLEN-1]};
  assign w_diff     = w_shift - {1'b0, r_div};
  assign w_fits     = ~w_diff[XLEN];
  assign w_rem_next = w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_last     = (r_cnt == CNT_W'(XLEN - 1));

  logic [XLEN-1:0] w_q_fix;
  logic [XLEN-1:0] w_r_fix;
  logic [XLEN-1:0] w_q_out;
  logic [XLEN-1:0] w_r_out;

  always_comb begin
    w_q_fix = r_flags.neg_q ? -r_quo : r_quo;
    w_r_fix = r_flags.neg_r ? -r_rem : r_rem;
    if (r_flags.div0) begin
      w_q_fix = '1;
      w_r_fix = r_a_ext;
    end else if (r_flags.ovf) begin
      w_q_fix = r_a_ext;
      w_r_fix = '0;
    end
  end

  generate
    if (XLEN > 32) begin : g_wext
      assign w_q_out = r_flags.word ? {{(XLEN-32){w_q_fix[31]}}, w_q_fix[31:0]} : w_q_fix;
      assign w_r_out = r_flags.word ? {{(XLEN-32){w_r_fix[31]}}, w_r_fix[31:0]} : w_r_fix;
    end else begin : g_nowext
      assign w_q_out = w_q_fix;
      assign w_r_out = w_r_fix;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= DIV_IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_a_ext     <= '0;
      r_flags     <= '0;
      r_ready     <= 1'b1;
      r_out_valid <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else if (flush) begin
      r_state     <= DIV_IDLE;
      r_ready     <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE, DIV_DONE: begin
          r_out_valid <= 1'b0;
          if (in_valid) begin
            r_state <= DIV_BUSY;
            r_ready <= 1'b0;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= w_a_abs;
            r_div   <= w_b_abs;
            r_a_ext <= w_a_ext;
            r_flags <= w_flags;
          end else begin
            r_state <= DIV_IDLE;
          end
        end
        DIV_BUSY: begin
`ifdef DIV_FAST_SPECIAL_EN
          if (r_flags.div0 || r_flags.ovf) begin
            r_state <= DIV_FIX;
          end else
`endif
          begin
            r_rem <= w_rem_next;
            r_quo <= {r_quo[XLEN-2:0], w_fits};
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_state <= DIV_FIX;
            end
          end
        end
        DIV_FIX: begin
          r_quotient  <= w_q_out;
          r_remainder <= w_r_out;
          r_out_valid <= 1'b1;
          r_ready     <= 1'b1;
          r_state     <= DIV_DONE;
        end
        default: begin
          r_state <= DIV_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ready     = r_ready;
  assign out_valid = r_out_valid;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;

endmodule

// File: tb/tb_ysyx_22041207_div_unit.sv
// Self-checking bench: directed corner cases plus random operations against an
// arithmetic reference model, including flush, async reset and back-to-back requests.
module tb_ysyx_22041207_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic [63:0] dividend = '0;
  logic [63:0] divisor = '0;
  logic        div_signed = 1'b0;
  logic        div_word = 1'b0;
  logic        ready;
  logic        out_valid;
  logic [63:0] quotient;
  logic [63:0] remainder;

  int checks = 0;
  int errors = 0;

  logic [63:0] cur_a, cur_b;
  logic        cur_s, cur_w;
  logic [63:0] held_q, held_r;

  always #5 clk = ~clk;

  ysyx_22041207_div_unit #(.XLEN(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .flush      (flush),
    .dividend   (dividend),
    .divisor    (divisor),
    .div_signed (div_signed),
    .div_word   (div_word),
    .ready      (ready),
    .out_valid  (out_valid),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // RISC-V division semantics computed with native arithmetic
  function automatic void ref_div(input logic [63:0] a, input logic [63:0] b,
                                  input logic s, input logic w,
                                  output logic [63:0] q, output logic [63:0] r,
                                  output bit special);
    logic [31:0] a32, b32, q32, r32;
    special = 1'b0;
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 32'd0) begin
        q32 = 32'hFFFF_FFFF; r32 = a32; special = 1'b1;
      end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = 32'd0; special = 1'b1;
      end else if (s) begin
        q32 = $signed(a32) / $signed(b32);
        r32 = $signed(a32) % $signed(b32);
      end else begin
        q32 = a32 / b32;
        r32 = a32 % b32;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 64'd0) begin
        q = '1; r = a; special = 1'b1;
      end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q = a; r = 64'd0; special = 1'b1;
      end else if (s) begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endfunction

  // Called at posedge+1 with the unit ready; returns just after the accept edge
  task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic s, input logic w);
    chk("ready_before_accept", {63'd0, ready}, 64'd1);
    dividend = a; divisor = b; div_signed = s; div_word = w; in_valid = 1'b1;
    cur_a = a; cur_b = b; cur_s = s; cur_w = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = {$urandom, $urandom};
    divisor  = {$urandom, $urandom};
  endtask

  task automatic finish_op(input string tag);
    logic [63:0] q_exp, r_exp;
    bit special;
    int lat, rdy_hi, lat_exp;
    ref_div(cur_a, cur_b, cur_s, cur_w, q_exp, r_exp, special);
    lat = 0;
    rdy_hi = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      if (ready) rdy_hi++;
      @(posedge clk); #1;
      lat++;
    end
    lat_exp = 65;
`ifdef DIV_FAST_SPECIAL_EN
    if (special) lat_exp = 2;
`endif
    chk({tag, "_latency"}, 64'(lat), 64'(lat_exp));
    chk({tag, "_ready_busy"}, 64'(rdy_hi), 64'd0);
    chk({tag, "_q"}, quotient, q_exp);
    chk({tag, "_r"}, remainder, r_exp);
    held_q = q_exp;
    held_r = r_exp;
    $display("op %s a=%h b=%h s=%0d w=%0d q=%h r=%h lat=%0d", tag, cur_a, cur_b, cur_s, cur_w,
             quotient, remainder, lat);
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                        input logic w, input string tag);
    start_op(a, b, s, w);
    finish_op(tag);
    @(posedge clk); #1;
    chk({tag, "_pulse_end"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_hold_q"}, quotient, held_q);
    chk({tag, "_hold_r"}, remainder, held_r);
  endtask

  function automatic logic [63:0] rnd_operand();
    case ($urandom_range(0, 6))
      0: return {$urandom, $urandom};
      1: return 64'($urandom_range(0, 20));
      2: return -64'($urandom_range(1, 20));
      3: return 64'd0;
      4: return 64'h8000_0000_0000_0000;
      5: return '1;
      default: return {32'($urandom_range(0, 3)), $urandom};
    endcase
  endfunction

  initial begin
    int saw;
    held_q = '0;
    held_r = '0;
    #12;
    chk("reset_ready", {63'd0, ready}, 64'd1);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_q", quotient, 64'd0);
    chk("reset_r", remainder, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    run_op(64'd100, 64'd7, 1'b0, 1'b0, "u100_7");
    run_op(-64'd7, 64'd2, 1'b1, 1'b0, "s-7_2");
    run_op(64'd7, -64'd2, 1'b1, 1'b0, "s7_-2");
    run_op(64'h1234, 64'd0, 1'b1, 1'b0, "s_div0");
    run_op(64'h1234, 64'd0, 1'b0, 1'b0, "u_div0");
    run_op(64'h8000_0000_0000_0000, '1, 1'b1, 1'b0, "s_ovf");
    run_op(64'h0000_0000_8000_0000, '1, 1'b1, 1'b1, "w_ovf");
    run_op(64'hDEAD_BEEF_FFFF_FFFE, 64'd2, 1'b0, 1'b1, "wu_upper");
    run_op(64'h0000_0000_8000_0000, 64'd0, 1'b0, 1'b1, "wu_div0");

    // flush part-way through the iterations
    start_op(64'd12345, 64'd67, 1'b0, 1'b0);
    repeat (29) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_ready", {63'd0, ready}, 64'd1);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_hold_q", quotient, held_q);
    saw = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (out_valid) saw++;
    end
    chk("flush_no_valid", 64'(saw), 64'd0);
    run_op(64'd1000, 64'd33, 1'b0, 1'b0, "after_flush");

    // asynchronous reset mid-BUSY
    start_op(64'd999, 64'd4, 1'b1, 1'b0);
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    chk("arst_ready", {63'd0, ready}, 64'd1);
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_q", quotient, 64'd0);
    chk("arst_r", remainder, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_op(-64'd1000, 64'd7, 1'b1, 1'b0, "after_rst");

    // back-to-back accept in the out_valid cycle
    start_op(64'd500, 64'd9, 1'b0, 1'b0);
    finish_op("b2b_first");
    start_op(-64'd81, -64'd4, 1'b1, 1'b0);
    chk("b2b_out_valid_drop", {63'd0, out_valid}, 64'd0);
    chk("b2b_hold_q", quotient, held_q);
    chk("b2b_hold_r", remainder, held_r);
    finish_op("b2b_second");
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      logic [63:0] a, b;
      a = rnd_operand();
      b = rnd_operand();
      run_op(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
